// File: rtl/gen_bus_rr_arbiter.sv
// gen_bus_rr_arbiter
//   Round-robin arbiter sharing one downstream generic bus port between
//   NUM_REQ upstream requesters (0 = icache, 1 = dcache, 2 = aux).
//   A grant is held for one whole transaction. An optional watchdog forces
//   completion when the downstream side stays busy too long.
//
//   state  | meaning
//   IDLE   | no grant; choose the next active requester after last_grant
//   ACTIVE | granted requester drives the downstream port until done/abort/timeout
//
// Ports
//   CLK, nRST                     clock, asynchronous active-low reset
//   req_addr/wdata/byte_en        per-requester packed request fields (slot i at i*W)
//   req_ren/req_wen               per-requester read/write requests
//   req_rdata                     read data broadcast to all requesters
//   req_busy                      per-requester busy; one-cycle low = completion
//   out_addr/wdata/byte_en/ren/wen downstream request
//   out_rdata/out_busy            downstream response
//   grant_valid/grant_id          current grant
//   timeout_err                   one-cycle pulse when the watchdog fires
module gen_bus_rr_arbiter #(
  parameter int          NUM_REQ        = 3,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hBAD1_BAD1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ*32-1:0]      req_wdata,
  input  logic [NUM_REQ*4-1:0]       req_byte_en,
  input  logic [NUM_REQ-1:0]         req_ren,
  input  logic [NUM_REQ-1:0]         req_wen,
  output logic [31:0]                req_rdata,
  output logic [NUM_REQ-1:0]         req_busy,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_wdata,
  output logic [3:0]                 out_byte_en,
  output logic                       out_ren,
  output logic                       out_wen,
  input  logic [31:0]                out_rdata,
  input  logic                       out_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  // Counter sized so TIMEOUT_CYCLES fits without wrapping; 1 bit when disabled.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_last_grant, w_last_nxt;
  logic [ID_W-1:0]   r_grant_id, w_gid_nxt;
  logic              r_grant_valid, w_gvalid_nxt;
  logic [WD_W-1:0]   r_wd_cnt, w_wd_nxt;

  logic [31:0]       w_addr_slot  [NUM_REQ];
  logic [31:0]       w_wdata_slot [NUM_REQ];
  logic [3:0]        w_be_slot    [NUM_REQ];
  logic [NUM_REQ-1:0] w_active;
  logic              w_found;
  logic [ID_W-1:0]   w_sel;
  logic              w_ren_g, w_wen_g, w_act_g;
  logic              w_done, w_timeout, w_abort;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign w_addr_slot[gi]  = req_addr[32*gi +: 32];
    assign w_wdata_slot[gi] = req_wdata[32*gi +: 32];
    assign w_be_slot[gi]    = req_byte_en[4*gi +: 4];
  end

  assign w_active = req_ren | req_wen;

  // Search upward from last_grant+1 so the most recent winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && w_active[ID_W'((int'(r_last_grant) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_sel   = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign w_ren_g   = req_ren[r_grant_id];
  assign w_wen_g   = req_wen[r_grant_id];
  assign w_act_g   = w_ren_g | w_wen_g;
  assign w_done    = (r_state == ACTIVE) && w_act_g && !out_busy;
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_state == ACTIVE) && w_act_g && out_busy
                     && (r_wd_cnt == WD_LAST);
  assign w_abort   = (r_state == ACTIVE) && !w_act_g;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_nxt;
      r_grant_id    <= w_gid_nxt;
      r_grant_valid <= w_gvalid_nxt;
      r_wd_cnt      <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last_grant;
    w_gid_nxt    = r_grant_id;
    w_gvalid_nxt = r_grant_valid;
    w_wd_nxt     = r_wd_cnt;
    case (r_state)
      IDLE: begin
        w_wd_nxt = '0;
        if (w_found) begin
          w_state_nxt  = ACTIVE;
          w_gid_nxt    = w_sel;
          w_gvalid_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_done || w_timeout || w_abort) begin
          w_state_nxt  = IDLE;
          w_gvalid_nxt = 1'b0;
          w_last_nxt   = r_grant_id;
          w_wd_nxt     = '0;
        end else if (out_busy && (r_wd_cnt != WD_LAST)) begin
          w_wd_nxt = r_wd_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_busy    = '1;
    req_rdata   = '0;
    out_addr    = '0;
    out_wdata   = '0;
    out_byte_en = '0;
    out_ren     = 1'b0;
    out_wen     = 1'b0;
    timeout_err = 1'b0;
    if (r_state == ACTIVE) begin
      out_addr    = w_addr_slot[r_grant_id];
      out_wdata   = w_wdata_slot[r_grant_id];
      out_byte_en = w_be_slot[r_grant_id];
      out_wen     = w_wen_g;
      out_ren     = w_ren_g && !w_wen_g;
      if (w_done) begin
        req_busy[r_grant_id] = 1'b0;
        req_rdata            = out_rdata;
      end else if (w_timeout) begin
        req_busy[r_grant_id] = 1'b0;
        req_rdata            = TIMEOUT_RDATA;
        timeout_err          = 1'b1;
      end
    end
  end

  assign grant_valid = r_grant_valid;
  // Report index 0 while idle so idle outputs match the reset view.
  assign grant_id    = r_grant_valid ? r_grant_id : '0;

endmodule
